bram_v3: RTL and testbench
==========================

BRAM_V3 -- requirements
Module: bram_v3

Interface
REQ-001 Parameter DATA_WIDTH, default 16: word width in bits; SHALL be a multiple of 8; NB = DATA_WIDTH/8 byte lanes.
REQ-002 Parameter ADDR_WIDTH, default 9: address width; DEPTH = 2**ADDR_WIDTH words.
REQ-003 Parameter WRITE_MODE, default 0: 0 = READ_FIRST, 1 = WRITE_FIRST, 2 = NO_CHANGE.
REQ-004 Parameter OUT_REG, default 0: 1 adds one output register stage.
REQ-005 Parameter INIT_CLEAR, default 1: 1 zero-fills the whole array after reset.
REQ-006 clka  input  1  clock; all state updates on the rising edge.
REQ-007 rsta_n  input  1  reset; asynchronous, active-low.
REQ-008 ena  input  1  access request strobe; one operation per asserted cycle.
REQ-009 wea  input  NB  byte write enables; wea != 0 with ena = write, wea == 0 with ena = read.
REQ-010 addra  input  ADDR_WIDTH  word address.
REQ-011 dina  input  DATA_WIDTH  write data; byte k = dina[8k+7:8k].
REQ-012 douta  output  DATA_WIDTH  read data.
REQ-013 douta_valid  output  1  one-cycle pulse marking douta as carrying an operation's result.
REQ-014 busy  input-blocking status, output  1  high while the clear sequence runs; requests are ignored.

Function
REQ-015 Stage 0: on edge E, ena, wea, addra, dina SHALL be captured into input registers when busy = 0; with busy = 1 the captured ena SHALL be 0.
REQ-016 Stage 1: on edge E+1, a captured write SHALL update only the enabled byte lanes of mem[addr]; disabled lanes SHALL keep their contents.
REQ-017 Stage 1 read data register, on edge E+1: a read SHALL load mem[addr].
REQ-018 Stage 1 write, READ_FIRST: SHALL load the pre-write word.
REQ-019 Stage 1 write, WRITE_FIRST: SHALL load the merged word (new enabled bytes, old disabled bytes).
REQ-020 Stage 1 write, NO_CHANGE: SHALL hold the data register.
REQ-021 douta_valid SHALL be high for the single cycle after edge E+1 (OUT_REG = 0) or after edge E+2 (OUT_REG = 1) for every read, and for every write unless WRITE_MODE = 2.
REQ-022 Latency from request capture to douta SHALL be 2 edges (OUT_REG = 0) or 3 edges (OUT_REG = 1); full throughput, one operation per cycle.
REQ-023 A write followed next cycle by a read of the same address SHALL return the newly written data in every mode.
REQ-024 douta SHALL hold its last value when douta_valid is low.
REQ-025 Clear FSM states: CLEAR and IDLE; reset release enters CLEAR if INIT_CLEAR = 1, otherwise IDLE.
REQ-026 CLEAR SHALL write all-zero words to addresses 0, 1, ..., DEPTH-1, one per cycle, with busy = 1 and no douta_valid.
REQ-027 After address DEPTH-1 the FSM SHALL go to IDLE, drop busy on the next cycle, and never re-enter CLEAR until the next reset.
REQ-028 The clear address counter SHALL be ADDR_WIDTH+1 bits so the terminal count does not wrap to 0.
REQ-029 Address arithmetic SHALL be plain unsigned ADDR_WIDTH bits; no out-of-range addresses exist.

Reset
REQ-030 rsta_n low SHALL immediately force douta = 0, douta_valid = 0, all pipeline valid/enable bits = 0, clear counter = 0.
REQ-031 During reset, busy SHALL be 1 if INIT_CLEAR = 1 and 0 otherwise.
REQ-032 Reset SHALL NOT initialise the array except through the clear sequence.
REQ-033 Reset asserted mid-clear or mid-pipeline SHALL discard in-flight operations and restart the clear sequence from address 0 after release.

Verification
REQ-034 INIT_CLEAR = 1, ADDR_WIDTH = 4 -> busy high exactly 16 cycles after release; read of each address returns 0x0000.
REQ-035 READ_FIRST: mem[5] = 0x1234; write 0xABCD with wea = 2'b01 to 5 -> douta 0x1234 valid after 2 edges; next read returns 0x12CD.
REQ-036 Same stimulus in WRITE_FIRST -> write returns 0x12CD; in NO_CHANGE -> no douta_valid, douta unchanged.
REQ-037 Back-to-back write 0x00FF to address 7 then read 7, OUT_REG = 1 -> read data 0x00FF with valid 3 edges after the read request.
REQ-038 ena held high during busy -> no writes land, no douta_valid pulses; memory remains all zero.
REQ-039 rsta_n pulsed low at clear address 8 -> douta = 0 and douta_valid = 0 asynchronously; clear restarts at 0 and completes a full DEPTH sweep.

Source files
------------

// File: rtl/bram_v3_if.sv
// Port bundle for bram_v3: request strobe, byte enables, address and data in; read data, valid and busy out.
// ena qualifies wea/addra/dina for exactly one operation per cycle and is dropped while busy is high; there is
// no backpressure. douta_valid pulses for one cycle with each result and douta holds its value in between.
interface bram_v3_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 9
);
  localparam int NB = DATA_WIDTH / 8;

  logic                  ena;
  logic [NB-1:0]         wea;
  logic [ADDR_WIDTH-1:0] addra;
  logic [DATA_WIDTH-1:0] dina;
  logic [DATA_WIDTH-1:0] douta;
  logic                  douta_valid;
  logic                  busy;

  modport master (output ena, wea, addra, dina, input douta, douta_valid, busy);
  modport slave  (input ena, wea, addra, dina, output douta, douta_valid, busy);
endinterface

// File: rtl/bram_v3.sv
// Single-port block RAM with byte enables, selectable write-read collision mode, optional output register
// and a post-reset zero-fill sequence that holds busy until every word has been cleared.
module bram_v3 #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 9,
  parameter int WRITE_MODE = 0,
  parameter int OUT_REG    = 0,
  parameter int INIT_CLEAR = 1
) (
  input  logic       clka,
  input  logic       rsta_n,
  bram_v3_if.slave   bus,
  output logic       o_dbg_state
);
  localparam int NB    = DATA_WIDTH / 8;
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] LAST_ADDR = (ADDR_WIDTH + 1)'(DEPTH - 1);

  typedef enum logic {ST_IDLE = 1'b0, ST_CLEAR = 1'b1} state_t;

  state_t                r_state;
  logic [ADDR_WIDTH:0]   r_clr_addr;
  logic                  r_busy;

  logic                  r_en;
  logic [NB-1:0]         r_we;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_din;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_dout;
  logic                  r_vld;

  logic [DATA_WIDTH-1:0] w_old;
  logic [DATA_WIDTH-1:0] w_merged;
  logic                  w_wr;
  logic                  w_clr_wr;

  // Clear sequencer: the extra counter bit keeps the terminal count distinct from address 0.
  always_ff @(posedge clka or negedge rsta_n) begin
    if (!rsta_n) begin
      r_state    <= (INIT_CLEAR != 0) ? ST_CLEAR : ST_IDLE;
      r_busy     <= (INIT_CLEAR != 0);
      r_clr_addr <= '0;
    end else if (r_state == ST_CLEAR) begin
      r_clr_addr <= r_clr_addr + 1'b1;
      if (r_clr_addr == LAST_ADDR) begin
        r_state <= ST_IDLE;
        r_busy  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clka or negedge rsta_n) begin
    if (!rsta_n) begin
      r_en   <= 1'b0;
      r_we   <= '0;
      r_addr <= '0;
      r_din  <= '0;
    end else begin
      r_en   <= bus.ena & ~r_busy;
      r_we   <= bus.wea;
      r_addr <= bus.addra;
      r_din  <= bus.dina;
    end
  end

  always_comb begin
    w_old    = r_mem[r_addr];
    w_merged = w_old;
    for (int k = 0; k < NB; k++) begin
      if (r_we[k]) w_merged[8*k +: 8] = r_din[8*k +: 8];
    end
  end

  assign w_wr     = r_en & (|r_we);
  assign w_clr_wr = (r_state == ST_CLEAR);

  // The array itself has no reset; only the clear sequence initialises it.
  always_ff @(posedge clka) begin
    if (w_clr_wr) begin
      r_mem[r_clr_addr[ADDR_WIDTH-1:0]] <= '0;
    end else if (w_wr) begin
      r_mem[r_addr] <= w_merged;
    end
  end

  always_ff @(posedge clka or negedge rsta_n) begin
    if (!rsta_n) begin
      r_dout <= '0;
      r_vld  <= 1'b0;
    end else begin
      r_vld <= r_en & (~(|r_we) | (WRITE_MODE != 2));
      if (r_en) begin
        if (!(|r_we))             r_dout <= w_old;
        else if (WRITE_MODE == 1) r_dout <= w_merged;
        else if (WRITE_MODE == 0) r_dout <= w_old;
      end
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [DATA_WIDTH-1:0] r_dout_q;
      logic                  r_vld_q;
      always_ff @(posedge clka or negedge rsta_n) begin
        if (!rsta_n) begin
          r_dout_q <= '0;
          r_vld_q  <= 1'b0;
        end else begin
          r_vld_q <= r_vld;
          if (r_vld) r_dout_q <= r_dout;
        end
      end
      assign bus.douta       = r_dout_q;
      assign bus.douta_valid = r_vld_q;
    end else begin : g_no_out_reg
      assign bus.douta       = r_dout;
      assign bus.douta_valid = r_vld;
    end
  endgenerate

  assign bus.busy    = r_busy;
  assign o_dbg_state = (r_state == ST_CLEAR);
endmodule

// File: tb/tb_bram_v3.sv
// Bench for bram_v3: four instances (READ_FIRST, WRITE_FIRST, NO_CHANGE, READ_FIRST+OUT_REG) share one
// stimulus stream and are compared every cycle against an operation-level memory model.
module tb_bram_v3;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s_ena = 1'b0;
  logic [1:0]  s_wea = '0;
  logic [3:0]  s_addr = '0;
  logic [15:0] s_din = '0;

  logic [15:0] dout [4];
  logic        vld [4];
  logic        bsy [4];
  logic        dbg [4];

  int n_checks = 0;
  int n_errors = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- DUTs ----------------
  bram_v3_if #(.DATA_WIDTH(16), .ADDR_WIDTH(4)) if_rf ();
  bram_v3_if #(.DATA_WIDTH(16), .ADDR_WIDTH(4)) if_wf ();
  bram_v3_if #(.DATA_WIDTH(16), .ADDR_WIDTH(4)) if_nc ();
  bram_v3_if #(.DATA_WIDTH(16), .ADDR_WIDTH(4)) if_or ();

  assign if_rf.ena = s_ena; assign if_rf.wea = s_wea; assign if_rf.addra = s_addr; assign if_rf.dina = s_din;
  assign if_wf.ena = s_ena; assign if_wf.wea = s_wea; assign if_wf.addra = s_addr; assign if_wf.dina = s_din;
  assign if_nc.ena = s_ena; assign if_nc.wea = s_wea; assign if_nc.addra = s_addr; assign if_nc.dina = s_din;
  assign if_or.ena = s_ena; assign if_or.wea = s_wea; assign if_or.addra = s_addr; assign if_or.dina = s_din;

  assign dout[0] = if_rf.douta; assign vld[0] = if_rf.douta_valid; assign bsy[0] = if_rf.busy;
  assign dout[1] = if_wf.douta; assign vld[1] = if_wf.douta_valid; assign bsy[1] = if_wf.busy;
  assign dout[2] = if_nc.douta; assign vld[2] = if_nc.douta_valid; assign bsy[2] = if_nc.busy;
  assign dout[3] = if_or.douta; assign vld[3] = if_or.douta_valid; assign bsy[3] = if_or.busy;

  bram_v3 #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .WRITE_MODE(0), .OUT_REG(0), .INIT_CLEAR(1))
    u_rf (.clka(clk), .rsta_n(rst_n), .bus(if_rf), .o_dbg_state(dbg[0]));
  bram_v3 #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .WRITE_MODE(1), .OUT_REG(0), .INIT_CLEAR(1))
    u_wf (.clka(clk), .rsta_n(rst_n), .bus(if_wf), .o_dbg_state(dbg[1]));
  bram_v3 #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .WRITE_MODE(2), .OUT_REG(0), .INIT_CLEAR(1))
    u_nc (.clka(clk), .rsta_n(rst_n), .bus(if_nc), .o_dbg_state(dbg[2]));
  bram_v3 #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .WRITE_MODE(0), .OUT_REG(1), .INIT_CLEAR(1))
    u_or (.clka(clk), .rsta_n(rst_n), .bus(if_or), .o_dbg_state(dbg[3]));

  // ---------------- reference model ----------------
  int          mode_of [4] = '{0, 1, 2, 0};
  int          lat_of  [4] = '{1, 1, 1, 2};
  logic [15:0] mm [DEPTH];
  logic [16:0] exp_q [4][$];
  logic [15:0] exp_dout [4];
  logic        exp_vld [4];
  logic        exp_busy;
  int          n_edges;

  task automatic model_reset();
    n_edges  = 0;
    exp_busy = 1'b1;
    for (int a = 0; a < DEPTH; a++) mm[a] = '0;
    for (int d = 0; d < 4; d++) begin
      exp_dout[d] = '0;
      exp_vld[d]  = 1'b0;
      exp_q[d].delete();
      for (int j = 0; j < lat_of[d]; j++) exp_q[d].push_back('0);
    end
  endtask

  task automatic model_step();
    logic        cap, is_wr;
    logic [15:0] old, merged;
    logic [16:0] ent;
    cap    = s_ena && (n_edges >= DEPTH);
    is_wr  = (s_wea != 2'b00);
    old    = mm[s_addr];
    merged = {s_wea[1] ? s_din[15:8] : old[15:8], s_wea[0] ? s_din[7:0] : old[7:0]};
    if (cap && is_wr) mm[s_addr] = merged;
    for (int d = 0; d < 4; d++) begin
      if (!cap)                 ent = '0;
      else if (!is_wr)          ent = {1'b1, old};
      else if (mode_of[d] == 1) ent = {1'b1, merged};
      else if (mode_of[d] == 0) ent = {1'b1, old};
      else                      ent = '0;
      exp_q[d].push_back(ent);
      ent = exp_q[d].pop_front();
      exp_vld[d] = ent[16];
      if (ent[16]) exp_dout[d] = ent[15:0];
    end
    if (n_edges < DEPTH) n_edges++;
    exp_busy = (n_edges < DEPTH);
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else        model_step();
    end
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        for (int d = 0; d < 4; d++) begin
          chk($sformatf("douta[%0d]", d), 32'(dout[d]), 32'(exp_dout[d]));
          chk($sformatf("douta_valid[%0d]", d), 32'(vld[d]), 32'(exp_vld[d]));
          chk($sformatf("busy[%0d]", d), 32'(bsy[d]), 32'(exp_busy));
          chk($sformatf("dbg_state[%0d]", d), 32'(dbg[d]), 32'(exp_busy));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", n_errors, n_checks);
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic en, input logic [1:0] we, input logic [3:0] a, input logic [15:0] d);
    s_ena  = en;
    s_wea  = we;
    s_addr = a;
    s_din  = d;
    @(negedge clk);
  endtask

  // Releases reset and counts busy cycles while hammering the port with writes that must be ignored.
  task automatic release_and_count(input string name);
    int cnt;
    cnt   = 0;
    rst_n = 1'b1;
    while (bsy[0] && cnt < 100) begin
      cnt++;
      s_ena  = 1'b1;
      s_wea  = 2'($urandom_range(1, 3));
      s_addr = 4'($urandom_range(0, 15));
      s_din  = 16'($urandom);
      @(negedge clk);
    end
    s_ena = 1'b0;
    s_wea = 2'b00;
    chk(name, 32'(cnt), 32'd16);
  endtask

  task automatic reset_outputs_check(input string name);
    for (int d = 0; d < 4; d++) begin
      chk($sformatf("%s_douta[%0d]", name, d), 32'(dout[d]), 32'h0);
      chk($sformatf("%s_valid[%0d]", name, d), 32'(vld[d]), 32'h0);
      chk($sformatf("%s_busy[%0d]", name, d), 32'(bsy[d]), 32'h1);
      chk($sformatf("%s_dbg[%0d]", name, d), 32'(dbg[d]), 32'h1);
    end
  endtask

  task automatic read_sweep();
    for (int a = 0; a < DEPTH; a++) drive(1'b1, 2'b00, 4'(a), 16'h0);
    repeat (3) drive(1'b0, 2'b00, 4'd0, 16'h0);
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic [1:0]  we;
    logic [3:0]  addr;
    logic [15:0] din;
    logic        rf_v;
    logic [15:0] rf_d;
    logic        wf_v;
    logic [15:0] wf_d;
    logic        nc_v;
    logic [15:0] nc_d;
  } vec_t;

  vec_t vecs [7];

  initial begin
    vecs[0] = '{2'b11, 4'd5, 16'h1234, 1'b1, 16'h0000, 1'b1, 16'h1234, 1'b0, 16'h0000};
    vecs[1] = '{2'b01, 4'd5, 16'hABCD, 1'b1, 16'h1234, 1'b1, 16'h12CD, 1'b0, 16'h0000};
    vecs[2] = '{2'b00, 4'd5, 16'h0000, 1'b1, 16'h12CD, 1'b1, 16'h12CD, 1'b1, 16'h12CD};
    vecs[3] = '{2'b11, 4'd7, 16'h00FF, 1'b1, 16'h0000, 1'b1, 16'h00FF, 1'b0, 16'h12CD};
    vecs[4] = '{2'b00, 4'd7, 16'h0000, 1'b1, 16'h00FF, 1'b1, 16'h00FF, 1'b1, 16'h00FF};
    vecs[5] = '{2'b10, 4'd7, 16'h5500, 1'b1, 16'h00FF, 1'b1, 16'h55FF, 1'b0, 16'h00FF};
    vecs[6] = '{2'b00, 4'd7, 16'h0000, 1'b1, 16'h55FF, 1'b1, 16'h55FF, 1'b1, 16'h55FF};

    // Reset values, then the initial clear with requests held high throughout.
    repeat (2) @(negedge clk);
    reset_outputs_check("reset");
    release_and_count("busy_cycles_init");
    read_sweep();

    // Collision-mode vectors: each result is checked two edges after its request.
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, vecs[i].we, vecs[i].addr, vecs[i].din);
      drive(1'b0, 2'b00, 4'd0, 16'h0);
      chk($sformatf("vec%0d_rf_valid", i), 32'(vld[0]), 32'(vecs[i].rf_v));
      chk($sformatf("vec%0d_rf_data", i),  32'(dout[0]), 32'(vecs[i].rf_d));
      chk($sformatf("vec%0d_wf_valid", i), 32'(vld[1]), 32'(vecs[i].wf_v));
      chk($sformatf("vec%0d_wf_data", i),  32'(dout[1]), 32'(vecs[i].wf_d));
      chk($sformatf("vec%0d_nc_valid", i), 32'(vld[2]), 32'(vecs[i].nc_v));
      chk($sformatf("vec%0d_nc_data", i),  32'(dout[2]), 32'(vecs[i].nc_d));
    end

    // Back-to-back write then read of the same word, with and without the output register.
    drive(1'b1, 2'b11, 4'd10, 16'h00FF);
    drive(1'b1, 2'b00, 4'd10, 16'h0000);
    drive(1'b0, 2'b00, 4'd0, 16'h0000);
    chk("rf_wr_rd_valid", 32'(vld[0]), 32'h1);
    chk("rf_wr_rd_data", 32'(dout[0]), 32'h00FF);
    chk("or_wr_result_data", 32'(dout[3]), 32'h0000);
    drive(1'b0, 2'b00, 4'd0, 16'h0000);
    chk("or_wr_rd_valid", 32'(vld[3]), 32'h1);
    chk("or_wr_rd_data", 32'(dout[3]), 32'h00FF);
    drive(1'b0, 2'b00, 4'd0, 16'h0000);
    chk("or_after_valid", 32'(vld[3]), 32'h0);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 16'($urandom));
    end
    repeat (3) drive(1'b0, 2'b00, 4'd0, 16'h0);

    // Fill with nonzero data so later clears are observable, then reset with reads in flight.
    for (int a = 0; a < DEPTH; a++) drive(1'b1, 2'b11, 4'(a), 16'hBE00 | 16'(a));
    repeat (4) drive(1'b1, 2'b00, 4'd3, 16'h0);
    chk("pre_reset_rf_data", 32'(dout[0]), 32'hBE03);
    #2;
    rst_n = 1'b0;
    s_ena = 1'b0;
    #1;
    reset_outputs_check("pipe_reset");

    // Release, let the clear reach address 8, then reset again mid-clear.
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    reset_outputs_check("midclear_reset");
    @(negedge clk);
    release_and_count("busy_cycles_restart");
    read_sweep();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
